// File: rtl/rnd_share_arb_pkg.sv
// Shared definitions for the random-word sharing arbiter.
// Optional feature macro: RND_DROP_CNT_EN (drop counter port and logic).
package rnd_share_arb_pkg;

    // Arbiter FSM state encodings
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_GRANT = 2'd2
    } state_e;

    // Width of a round-robin pointer over n requesters (at least one bit)
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rnd_rr_pick.sv
// Combinational round-robin search: first set request at or after rr_ptr, wrapping.
module rnd_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] pick_oh_c,
    output logic [PTR_W-1:0]   pick_idx_c,
    output logic               pick_any_c
);

    int unsigned cand;

    // Scan offsets from farthest to nearest so the nearest set request wins
    always_comb begin
        pick_oh_c  = '0;
        pick_idx_c = '0;
        pick_any_c = 1'b0;
        cand       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(rr_ptr) + (NUM_REQ - 1 - k)) % NUM_REQ;
            if (req[cand]) begin
                pick_oh_c       = '0;
                pick_oh_c[cand] = 1'b1;
                pick_idx_c      = PTR_W'(cand);
                pick_any_c      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rnd_share_arb.sv
// Shares one random-word source among NUM_REQ consumers: buffers one word,
// grants it round-robin, delivers each word exactly once.
// Optional feature macro: RND_DROP_CNT_EN (saturating count of dropped words).
module rnd_share_arb
    import rnd_share_arb_pkg::*;
#(
    parameter int unsigned DATA_LEN = 8,
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rnd_valid,
    input  logic [DATA_LEN-1:0] rnd_num,
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [DATA_LEN-1:0] gnt_data,
    output logic                buf_full
`ifdef RND_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0]    drop_cnt
`endif
);

    localparam int unsigned PTR_W = ptr_width(NUM_REQ);

    state_e              state;
    logic [DATA_LEN-1:0] word;
    logic [PTR_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0]  pick_oh_c;
    logic [PTR_W-1:0]    pick_idx_c;
    logic                pick_any_c;
    logic [PTR_W-1:0]    ptr_next_c;

    rnd_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req        (req),
        .rr_ptr     (rr_ptr),
        .pick_oh_c  (pick_oh_c),
        .pick_idx_c (pick_idx_c),
        .pick_any_c (pick_any_c)
    );

    // Pointer moves to the requester just after the winner, wrapping
    always_comb begin
        ptr_next_c = '0;
        if (pick_idx_c != PTR_W'(NUM_REQ - 1)) begin
            ptr_next_c = pick_idx_c + PTR_W'(1);
        end
    end

    // Arbiter FSM with holding register, grant pulse and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            word     <= '0;
            gnt      <= '0;
            gnt_data <= '0;
            buf_full <= 1'b0;
            rr_ptr   <= '0;
        end else begin
            gnt      <= '0;
            gnt_data <= '0;
            case (state)
                ST_EMPTY: begin
                    if (rnd_valid) begin
                        word     <= rnd_num;
                        buf_full <= 1'b1;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // a word arriving here is dropped; the held word stays
                    if (pick_any_c) begin
                        gnt      <= pick_oh_c;
                        gnt_data <= word;
                        rr_ptr   <= ptr_next_c;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (rnd_valid) begin
                        word  <= rnd_num;
                        state <= ST_HOLD;
                    end else begin
                        buf_full <= 1'b0;
                        state    <= ST_EMPTY;
                    end
                end
                default: begin
                    buf_full <= 1'b0;
                    state    <= ST_EMPTY;
                end
            endcase
        end
    end

`ifdef RND_DROP_CNT_EN
    // Saturating count of words that arrive while one is already held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if ((state == ST_HOLD) && rnd_valid && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W == 0);
`endif

endmodule

// File: tb/tb_rnd_share_arb.sv
// Scoreboard bench for rnd_share_arb: queue-level reference model predicts
// grants, a negedge monitor compares. Honours RND_DROP_CNT_EN.
module tb_rnd_share_arb;

    localparam int unsigned DATA_LEN = 8;
    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned CNT_W    = 2;
    localparam int          DROP_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [NUM_REQ-1:0]  oh;
        logic [DATA_LEN-1:0] data;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                rnd_valid;
    logic [DATA_LEN-1:0] rnd_num;
    logic [NUM_REQ-1:0]  req;
    logic [NUM_REQ-1:0]  gnt;
    logic [DATA_LEN-1:0] gnt_data;
    logic                buf_full;
`ifdef RND_DROP_CNT_EN
    logic [CNT_W-1:0]    drop_cnt;
`endif

    rnd_share_arb #(
        .DATA_LEN (DATA_LEN),
        .NUM_REQ  (NUM_REQ),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rnd_valid (rnd_valid),
        .rnd_num   (rnd_num),
        .req       (req),
        .gnt       (gnt),
        .gnt_data  (gnt_data),
        .buf_full  (buf_full)
`ifdef RND_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t                exp_q[$];
    logic [DATA_LEN-1:0] held_q[$];
    int                  m_ptr   = 0;
    int                  m_drops = 0;
    logic                exp_buf = 1'b0;
    logic [7:0]          lfsr    = 8'h81;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Reference model: at most one word waits; requests served round-robin from m_ptr
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                held_q.delete();
                exp_q.delete();
                m_ptr   = 0;
                m_drops = 0;
                exp_buf = 1'b0;
            end else begin
                logic granted;
                granted = 1'b0;
                if (held_q.size() > 0) begin
                    if (rnd_valid && m_drops < DROP_MAX) m_drops++;
                    if (req != 0) begin
                        int   w;
                        bit   found;
                        exp_t e;
                        found = 0;
                        w = 0;
                        for (int k = 0; k < NUM_REQ; k++) begin
                            int c;
                            c = (m_ptr + k) % NUM_REQ;
                            if (!found && req[c]) begin
                                w = c;
                                found = 1;
                            end
                        end
                        e.oh = '0;
                        e.oh[w] = 1'b1;
                        e.data = held_q.pop_front();
                        exp_q.push_back(e);
                        m_ptr = (w + 1) % NUM_REQ;
                        granted = 1'b1;
                    end
                end else if (rnd_valid) begin
                    held_q.push_back(rnd_num);
                end
                exp_buf = (held_q.size() > 0) || granted;
            end
        end
    end

    // Monitor: compare outputs against model away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_gnt", 32'(gnt), 0);
                chk("rst_gnt_data", 32'(gnt_data), 0);
                chk("rst_buf_full", 32'(buf_full), 0);
`ifdef RND_DROP_CNT_EN
                chk("rst_drop_cnt", 32'(drop_cnt), 0);
`endif
            end else begin
                if (gnt != 0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_gnt", 32'(gnt), 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("gnt", 32'(gnt), 32'(e.oh));
                        chk("gnt_data", 32'(gnt_data), 32'(e.data));
                    end
                end else begin
                    chk("idle_gnt_data", 32'(gnt_data), 0);
                end
                chk("buf_full", 32'(buf_full), 32'(exp_buf));
`ifdef RND_DROP_CNT_EN
                chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
`endif
            end
        end
    end

    // One generator pulse, then idle until gap cycles have elapsed
    task automatic send_word(input int gap);
        @(negedge clk);
        rnd_valid = 1'b1;
        rnd_num   = lfsr;
        @(negedge clk);
        rnd_valid = 1'b0;
        lfsr      = lfsr_next(lfsr);
        repeat (gap - 2) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int since;
        bit seen;
        rst_n     = 1'b0;
        rnd_valid = 1'b0;
        rnd_num   = '0;
        req       = '0;
        idle(3);
        rst_n = 1'b1;

        // single consumer, generator cadence
        req = 4'b0001;
        repeat (6) send_word(8);

        // all consumers: rotation 0,1,2,3,...
        req = 4'b1111;
        repeat (8) send_word(8);
        idle(4);

        // nobody requests: first word held, later ones dropped
        req = 4'b0000;
        repeat (3) send_word(8);
        req = 4'b0100;
        idle(4);

        // saturating drops
        req = 4'b0000;
        repeat (6) send_word(3);
        req = 4'b1000;
        idle(4);

        // back-to-back words: new word lands in the grant cycle
        req = 4'b1111;
        repeat (6) send_word(2);
        idle(4);

        // reset asserted while a grant pulse is on the outputs
        req = 4'b0010;
        send_word(2);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (gnt != 0) seen = 1;
        end
        chk("grant_before_reset_seen", 32'(seen), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_gnt", 32'(gnt), 0);
        chk("async_rst_buf_full", 32'(buf_full), 0);
        chk("async_rst_gnt_data", 32'(gnt_data), 0);
        idle(2);
        rst_n = 1'b1;
        req = 4'b1111;
        send_word(4);
        idle(4);

        // randomized traffic
        since = 2;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 1) == 0) req = NUM_REQ'($urandom_range(0, 15));
            if (since >= 1 && $urandom_range(0, 2) == 0) begin
                rnd_valid = 1'b1;
                rnd_num   = lfsr;
                lfsr      = lfsr_next(lfsr);
                since     = 0;
            end else begin
                rnd_valid = 1'b0;
                since++;
            end
        end
        @(negedge clk);
        rnd_valid = 1'b0;
        req = 4'b1111;
        idle(10);
        chk("drain_expected_empty", 32'(exp_q.size()), 0);
        chk("drain_held_empty", 32'(buf_full), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
